// File: rtl/conv_frame_feeder_if.sv
// Handshake bundle between the frame source / encoder sink and conv_frame_feeder.
interface conv_frame_feeder_if #(
    parameter int k  = 1,
    parameter int m  = 4,
    parameter int W  = 8,
    parameter int LW = 8
);
    logic          start;
    logic [LW-1:0] frame_len;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic          out_ready;
    logic [k-1:0]  enc_I;
    logic          enc_enable;
    logic          enc_restart;
    logic          busy;
    logic          frame_done;

    // Frame source / encoder side: issues frames and words, observes encoder drive.
    modport master (
        output start, frame_len, in_data, in_valid, out_ready,
        input  in_ready, enc_I, enc_enable, enc_restart, busy, frame_done
    );

    // Feeder side.
    modport slave (
        input  start, frame_len, in_data, in_valid, out_ready,
        output in_ready, enc_I, enc_enable, enc_restart, busy, frame_done
    );
endinterface

// File: rtl/conv_frame_feeder.sv
// Frames message words for the convolutional encoder: restart, MSB-first
// serialisation k bits per step, then zero tail steps to flush the encoder.
module conv_frame_feeder #(
    parameter int k  = 1,
    parameter int m  = 4,
    parameter int W  = 8,
    parameter int LW = 8
) (
    input logic                 clk,
    input logic                 reset,
    conv_frame_feeder_if.slave  bus
);
    localparam int STEPS      = W / k;
    localparam int TAIL_STEPS = (m - 1) / k;
    localparam int MAX_STEPS  = (STEPS > TAIL_STEPS) ? STEPS : TAIL_STEPS;
    localparam int SW         = $clog2(MAX_STEPS + 1);

    localparam logic [SW-1:0] LAST_SHIFT = SW'(STEPS - 1);
    localparam logic [SW-1:0] LAST_TAIL  = SW'((TAIL_STEPS > 0) ? TAIL_STEPS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_FETCH,
        S_SHIFT,
        S_TAIL,
        S_DONE
    } state_t;

    // With no tail steps (m == k) the frame ends straight after the last data step.
    localparam state_t AFTER_DATA = (TAIL_STEPS == 0) ? S_DONE : S_TAIL;

    state_t        state_q, state_d;
    logic [LW-1:0] word_q, word_d;
    logic [SW-1:0] step_q, step_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic          restart_q, restart_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          shift_q, shift_d;
    logic          step_en_q, step_en_d;

    // Next-state, counter and shift-register update; outputs decoded from next state.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        step_d  = step_q;
        shreg_d = shreg_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    word_d  = bus.frame_len;
                    state_d = S_RST;
                end
            end
            S_RST: begin
                step_d  = '0;
                state_d = (word_q != '0) ? S_FETCH : AFTER_DATA;
            end
            S_FETCH: begin
                if (bus.in_valid) begin
                    shreg_d = bus.in_data;
                    word_d  = word_q - LW'(1);
                    step_d  = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.out_ready) begin
                    shreg_d = shreg_q << k;
                    if (step_q == LAST_SHIFT) begin
                        step_d  = '0;
                        state_d = (word_q != '0) ? S_FETCH : AFTER_DATA;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            S_TAIL: begin
                if (bus.out_ready) begin
                    if (step_q == LAST_TAIL) begin
                        step_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        restart_d  = (state_d == S_RST);
        in_ready_d = (state_d == S_FETCH);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        shift_d    = (state_d == S_SHIFT);
        step_en_d  = (state_d == S_SHIFT) || (state_d == S_TAIL);
    end

    // State, counters and registered output flags with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            step_q     <= '0;
            shreg_q    <= '0;
            restart_q  <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            shift_q    <= 1'b0;
            step_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            step_q     <= step_d;
            shreg_q    <= shreg_d;
            restart_q  <= restart_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            shift_q    <= shift_d;
            step_en_q  <= step_en_d;
        end
    end

    // enc_enable must follow out_ready in the same cycle, so it is gated here.
    assign bus.enc_I       = shift_q ? shreg_q[W-1 -: k] : '0;
    assign bus.enc_enable  = step_en_q & bus.out_ready;
    assign bus.enc_restart = restart_q;
    assign bus.in_ready    = in_ready_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = done_q;
endmodule

// File: tb/tb_conv_frame_feeder.sv
// Directed bench for conv_frame_feeder (k=1, m=4, W=8, LW=8).
module tb_conv_frame_feeder;
    logic clk;
    logic reset;

    conv_frame_feeder_if #(.k(1), .m(4), .W(8), .LW(8)) bus ();

    conv_frame_feeder #(.k(1), .m(4), .W(8), .LW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Per-frame observations, filled by run_frame.
    logic [31:0] bits;
    int          nbits, first_en, restart_cnt, restart_first, done_cyc;
    int          inready_cnt, post_restart;
    logic        low_en, low_i_all, busy_c1, busy_post;
    logic [5:0]  abort_vec;
    logic        en_trace [0:80];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one frame; cycle c counts from the edge that samples start (cycle 1 = RST).
    // Low windows and pulses are given in those cycle numbers; abort_cyc asserts reset.
    task automatic run_frame(input int n, input logic [7:0] w0, input logic [7:0] w1,
                             input int or_lo_a, input int or_lo_b,
                             input int iv_lo_a, input int iv_lo_b,
                             input int start_cyc, input int abort_cyc);
        int idx;
        bits = '0; nbits = 0; first_en = -1; restart_cnt = 0; restart_first = -1;
        done_cyc = -1; inready_cnt = 0; post_restart = 0;
        low_en = 1'b0; low_i_all = 1'b1; busy_c1 = 1'b0; busy_post = 1'b1;
        abort_vec = '1;
        for (int i = 0; i <= 80; i++) en_trace[i] = 1'b0;
        idx = 0;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.frame_len = 8'(n);
        bus.in_data   = w0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            bus.out_ready = !(c >= or_lo_a && c <= or_lo_b);
            bus.in_valid  = !(c >= iv_lo_a && c <= iv_lo_b);
            bus.start     = (c == start_cyc);
            bus.in_data   = (idx == 0) ? w0 : w1;
            reset         = (c == abort_cyc);
            @(negedge clk);
            if (abort_cyc > 0 && c == abort_cyc + 1) begin
                abort_vec = {bus.in_ready, bus.enc_I, bus.enc_enable,
                             bus.enc_restart, bus.busy, bus.frame_done};
                break;
            end
            if (c == 1) busy_c1 = bus.busy;
            en_trace[c] = bus.enc_enable;
            if (bus.enc_enable) begin
                bits = (bits << 1) | 32'(bus.enc_I);
                nbits++;
                if (first_en < 0) first_en = c;
            end
            if (!bus.out_ready) begin
                low_en    = low_en | bus.enc_enable;
                low_i_all = low_i_all & bus.enc_I[0];
            end
            if (bus.enc_restart) begin
                restart_cnt++;
                if (restart_first < 0) restart_first = c;
                if (done_cyc > 0) post_restart++;
            end
            if (bus.in_ready) inready_cnt++;
            if (bus.in_valid && bus.in_ready) idx++;
            if (done_cyc > 0 && c == done_cyc + 1) busy_post = bus.busy;
            if (bus.frame_done && done_cyc < 0) done_cyc = c;
            if (done_cyc > 0 && c >= done_cyc + 6) break;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.frame_len = '0; bus.in_data = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({bus.in_ready, bus.enc_I, bus.enc_enable,
                                    bus.enc_restart, bus.busy, bus.frame_done}), 32'h0);
        #1 reset = 1'b0;

        // Single word 0xB4
        run_frame(1, 8'hB4, 8'h00, 0, -1, 0, -1, 0, 0);
        check("t1_bits", bits, 32'h5A0);
        check("t1_nbits", 32'(nbits), 32'd11);
        check("t1_first_en", 32'(first_en), 32'd3);
        check("t1_restart_cyc", 32'(restart_first), 32'd1);
        check("t1_restart_cnt", 32'(restart_cnt), 32'd1);
        check("t1_done_cyc", 32'(done_cyc), 32'd14);
        check("t1_inready_cnt", 32'(inready_cnt), 32'd1);
        check("t1_busy_c1", 32'(busy_c1), 32'd1);
        check("t1_busy_post", 32'(busy_post), 32'd0);

        // Two words 0xFF, 0x01 with the FETCH bubble at cycle 11
        run_frame(2, 8'hFF, 8'h01, 0, -1, 0, -1, 0, 0);
        check("t2_bits", bits, 32'h7F808);
        check("t2_nbits", 32'(nbits), 32'd19);
        check("t2_bubble_en", 32'(en_trace[11]), 32'd0);
        check("t2_done_cyc", 32'(done_cyc), 32'd23);
        check("t2_inready_cnt", 32'(inready_cnt), 32'd2);

        // Backpressure on cycles 5-6
        run_frame(1, 8'hB4, 8'h00, 5, 6, 0, -1, 0, 0);
        check("t3_bits", bits, 32'h5A0);
        check("t3_nbits", 32'(nbits), 32'd11);
        check("t3_low_enable", 32'(low_en), 32'd0);
        check("t3_low_hold_I", 32'(low_i_all), 32'd1);
        check("t3_done_cyc", 32'(done_cyc), 32'd16);

        // Tail-only frame
        run_frame(0, 8'h00, 8'h00, 0, -1, 0, -1, 0, 0);
        check("t4_bits", bits, 32'h0);
        check("t4_nbits", 32'(nbits), 32'd3);
        check("t4_first_en", 32'(first_en), 32'd2);
        check("t4_restart_cyc", 32'(restart_first), 32'd1);
        check("t4_done_cyc", 32'(done_cyc), 32'd5);
        check("t4_inready_cnt", 32'(inready_cnt), 32'd0);

        // in_valid withheld for FETCH cycles 2-5, stray start during SHIFT at cycle 8
        run_frame(1, 8'hB4, 8'h00, 0, -1, 2, 5, 8, 0);
        check("t5_bits", bits, 32'h5A0);
        check("t5_done_cyc", 32'(done_cyc), 32'd18);
        check("t5_restart_cnt", 32'(restart_cnt), 32'd1);
        check("t5_post_restart", 32'(post_restart), 32'd0);

        // Reset at cycle 7, then a fresh frame
        run_frame(1, 8'hB4, 8'h00, 0, -1, 0, -1, 0, 7);
        check("t6_abort_outputs", 32'(abort_vec), 32'h0);
        run_frame(1, 8'hB4, 8'h00, 0, -1, 0, -1, 0, 0);
        check("t6_bits", bits, 32'h5A0);
        check("t6_nbits", 32'(nbits), 32'd11);
        check("t6_done_cyc", 32'(done_cyc), 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/conv_frame_feeder.md
# conv_frame_feeder

Upstream framing stage for the convolutional encoder. Accepts W-bit message words over a valid/ready handshake, restarts the encoder at frame start, serializes each word MSB-first k bits per step into the encoder input, then flushes the encoder shift register with zero tail bits so every frame ends in the all-zero state expected by the Viterbi decoder's traceback. The block drives the encoder's `I`, `enable` and `restart` inputs directly.

## Interface
- `k`, 1: encoder input bits per step; must divide W.
- `m`, 4: encoder constraint length; tail length is TAIL = ceil((m-k)/k) steps.
- `W`, 8: message word width.
- `LW`, 8: width of the frame length field.

- `clk`  in  1  clock. One clock domain; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin frame; sampled only in IDLE.
- `frame_len`  in  LW  number of words in the frame; latched when `start` is accepted.
- `in_data`  in  W  message word.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  word accepted on an edge where `in_valid && in_ready`.
- `out_ready`  in  1  downstream can take a codeword this cycle.
- `enc_I`  out  k  encoder input bits.
- `enc_enable`  out  1  encoder advances this cycle.
- `enc_restart`  out  1  clear encoder state.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, RST, FETCH, SHIFT, TAIL, DONE.
- IDLE: `start` = 1 → latch `frame_len` into the word counter and go to RST. Otherwise stay in IDLE.
- RST: `enc_restart` = 1 for exactly one cycle. Next state is FETCH if the word count is nonzero, else TAIL.
- FETCH: `in_ready` = 1.
  - On `in_valid`, load `in_data` into the shift register, decrement the word count, clear the step counter and go to SHIFT.
  - Without `in_valid`, stay in FETCH.
- SHIFT:
  - `enc_I` = shift register [W-1 -: k].
  - `enc_enable` = `out_ready`.
  - On each enabled cycle, shift left by k and increment the step counter.
  - After step W/k-1 is enabled: go to FETCH if words remain, else TAIL.
- TAIL:
  - `enc_I` = 0, `enc_enable` = `out_ready`.
  - After TAIL enabled steps, go to DONE.
- DONE: `frame_done` = 1 for one cycle, then IDLE.
- `enc_I` = 0 in every state except SHIFT. `enc_enable` = 0 outside SHIFT and TAIL.
- `start` asserted in any state other than IDLE is ignored. It is not queued.
- `in_ready` is high only in FETCH. No prefetch, so each word costs one bubble cycle.
- When `out_ready` is low, the shift register, step counter and `enc_I` all hold. Bits are never dropped or repeated.
- Counter widths:
  - Step counter: clog2(max(W/k, TAIL)+1) bits.
  - Word counter: LW bits.
- `frame_len` = 0 sends a tail-only frame: RST, TAIL, DONE.

## Timing
- Reset: state = IDLE; all outputs 0; counters and shift register cleared.
- Reset mid-frame returns the block to IDLE on the next edge. No `frame_done` is issued. The block does not issue `enc_restart`, because the encoder is reset separately.
- Latency with `start` sampled at edge E0 and `out_ready`/`in_valid` held high:
  - Cycle 1: RST.
  - Word j (0-based): FETCH at cycle 2+9j, SHIFT at cycles 3+9j to 10+9j (W=8, k=1).
  - TAIL: cycles 9N+2 to 9N+4 (m=4).
  - `frame_done`: cycle 9N+5.
- Each low cycle of `in_valid` in FETCH, or of `out_ready` in SHIFT/TAIL, delays every later event by one cycle.
- `busy` goes high in the cycle after `start` is sampled and goes low in the cycle after DONE.

## Test plan
- Single word: reset, `start` with `frame_len` = 1, `in_data` = 0xB4, other inputs held high.
  - `enc_I` on enabled cycles 3–13 = 1,0,1,1,0,1,0,0,0,0,0.
  - `enc_restart` at cycle 1; `frame_done` at cycle 14.
- Two words 0xFF, 0x01: 16 data bits, with a non-enabled bubble at cycle 11, then 3 zero tail bits. `frame_done` at cycle 23.
- Backpressure: drop `out_ready` low for cycles 5–6 of the single-word frame.
  - `enc_enable` is 0 and `enc_I` holds 1 during those cycles.
  - The bit sequence is unchanged and `frame_done` moves to cycle 16.
- `frame_len` = 0: `enc_restart` at cycle 1, three zero enabled steps at cycles 2–4, `frame_done` at cycle 5, `in_ready` never asserted.
- `start` pulsed during SHIFT is ignored and no second frame follows. `in_valid` withheld for 4 FETCH cycles delays `frame_done` by 4.
- `reset` asserted at cycle 7 of a frame: at the next edge all outputs are 0 and the block is in IDLE. A fresh `start` then produces a complete, correct frame.
